// File: rtl/spi_imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Package : spi_imem_loader_pkg
// Brief   : Opcode set, header magic and loader state encoding for the SPI loader.
// Rev     : 1.0
// ============================================================================
package spi_imem_loader_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [7:0] HDR_MAGIC = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_DATA   = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERROR  = 3'd4
    } ldr_state_e;

    // True when the main decoder understands this opcode.
    function automatic logic op_supported(input logic [6:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
            OP_BRANCH, OP_JAL, OP_LUI: ok = 1'b1;
            default:                   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_imem_loader_sync_edge.sv
`default_nettype none
// ============================================================================
// Module : spi_sync_edge
// Brief  : Multi-flop synchronizer with single-cycle rise/fall pulses.
// Rev    : 1.0
// ============================================================================
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   w_level;

    generate
        if (SYNC_STAGES > 1) begin : g_multi
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) sync_q <= {SYNC_STAGES{RESET_VAL}};
                else       sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            end
        end else begin : g_single
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) sync_q <= {SYNC_STAGES{RESET_VAL}};
                else       sync_q <= async_i;
            end
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) prev_q <= RESET_VAL;
        else       prev_q <= w_level;
    end

    assign w_level = sync_q[SYNC_STAGES-1];
    assign rise_o  = w_level & ~prev_q;
    assign fall_o  = ~w_level & prev_q;

endmodule
`default_nettype wire

// File: rtl/spi_imem_loader.sv
`default_nettype none
// ============================================================================
// Module : spi_imem_loader
// Brief  : SPI-slave boot loader writing header-counted words into IMEM.
// Rev    : 1.0
// ============================================================================
module spi_imem_loader
    import spi_imem_loader_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sclk_i,
    input  logic              cs_n_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              cpu_rst_hold_o,
    output logic              load_done_o,
    output logic              bad_op_o
);

    localparam int          CNT_W       = ADDR_W + 1;
    localparam logic [16:0] c_max_words = 17'(2**ADDR_W);

    logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall, w_mosi;
    logic [SYNC_STAGES-1:0] mosi_sync_q;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (sclk_i),
        .rise_o  (w_sclk_rise),
        .fall_o  (w_sclk_fall)
    );

    // Idle-high reset value keeps a reset from looking like a select.
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (cs_n_i),
        .rise_o  (w_cs_rise),
        .fall_o  (w_cs_fall)
    );

    generate
        if (SYNC_STAGES > 1) begin : g_mosi_multi
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) mosi_sync_q <= '0;
                else       mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            end
        end else begin : g_mosi_single
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) mosi_sync_q <= '0;
                else       mosi_sync_q <= mosi_i;
            end
        end
    endgenerate
    assign w_mosi = mosi_sync_q[SYNC_STAGES-1];

    ldr_state_e        state_q, state_d, w_state_after;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [30:0]       shift_q, shift_d;
    logic [31:0]       echo_q, echo_d;
    logic              miso_q, miso_d;
    logic [CNT_W-1:0]  ptr_q, ptr_d, cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              bad_q, bad_d;

    logic        w_active, w_shift, w_word_done, w_hdr_ok, w_last;
    logic [31:0] w_word;

    assign w_active    = (state_q == ST_HEADER) || (state_q == ST_DATA);
    assign w_shift     = w_sclk_rise && w_active;
    assign w_word      = {shift_q, w_mosi};
    assign w_word_done = w_shift && (bit_cnt_q == 5'd31);
    assign w_hdr_ok    = (w_word[31:24] == HDR_MAGIC) && ({1'b0, w_word[15:0]} <= c_max_words);
    assign w_last      = (ptr_q + CNT_W'(1)) == cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // A word finishing in the same cycle as deselect is resolved before cs_n is judged.
    always_comb begin
        w_state_after = state_q;
        case (state_q)
            ST_HEADER: begin
                if (w_word_done) begin
                    if (!w_hdr_ok)                  w_state_after = ST_ERROR;
                    else if (w_word[15:0] == 16'd0) w_state_after = ST_DONE;
                    else                            w_state_after = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_word_done && w_last) w_state_after = ST_DONE;
            end
            default: ;
        endcase
        state_d = w_state_after;
        if (w_cs_rise && ((w_state_after == ST_HEADER) || (w_state_after == ST_DATA)))
            state_d = ST_ERROR;
        if (w_cs_fall)
            state_d = ST_HEADER;
    end

    always_comb begin
        cpu_rst_hold_o = (state_q != ST_DONE);
        load_done_o    = (state_q == ST_DONE);
    end

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        echo_d    = echo_q;
        miso_d    = miso_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        bad_d     = bad_q;
        if (w_cs_fall) begin
            bit_cnt_d = '0;
            shift_d   = '0;
            echo_d    = '0;
            miso_d    = 1'b0;
            ptr_d     = '0;
            cnt_d     = '0;
            bad_d     = 1'b0;
        end else begin
            if (w_shift) begin
                shift_d   = w_word[30:0];
                bit_cnt_d = bit_cnt_q + 5'd1;
            end
            if (w_word_done) begin
                echo_d = w_word;
                if ((state_q == ST_HEADER) && w_hdr_ok)
                    cnt_d = w_word[CNT_W-1:0];
                if (state_q == ST_DATA) begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q[ADDR_W-1:0];
                    wdata_d = w_word;
                    ptr_d   = ptr_q + CNT_W'(1);
                    if (!op_supported(w_word[6:0]))
                        bad_d = 1'b1;
                end
            end
            if (w_sclk_fall && (state_q != ST_IDLE)) begin
                miso_d = echo_q[31];
                echo_d = {echo_q[30:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            echo_q    <= '0;
            miso_q    <= 1'b0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            bad_q     <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            echo_q    <= echo_d;
            miso_q    <= miso_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            bad_q     <= bad_d;
        end
    end

    assign miso_o       = miso_q;
    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign bad_op_o     = bad_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_imem_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_spi_imem_loader
// Brief  : Directed and randomized SPI boot-load sessions against a word-level model.
// Rev    : 1.0
// ============================================================================
module tb_spi_imem_loader;

    localparam int ADDR_W = 8;
    localparam int T_HALF = 50;

    logic              clk, rst, sclk, cs_n, mosi;
    logic              miso, imem_we, cpu_rst_hold, load_done, bad_op;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    int tests = 0;
    int fails = 0;

    logic [ADDR_W+31:0] wr_q[$];
    logic [31:0]        tx_q[$];

    spi_imem_loader #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .sclk_i         (sclk),
        .cs_n_i         (cs_n),
        .mosi_i         (mosi),
        .miso_o         (miso),
        .imem_we_o      (imem_we),
        .imem_addr_o    (imem_addr),
        .imem_wdata_o   (imem_wdata),
        .cpu_rst_hold_o (cpu_rst_hold),
        .load_done_o    (load_done),
        .bad_op_o       (bad_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (imem_we) wr_q.push_back({imem_addr, imem_wdata});

    function automatic bit op_ok(input logic [6:0] op);
        return op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                          7'b1100011, 7'b1101111, 7'b0110111};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " we"},    64'(imem_we), 64'd0);
        chk({tag, " addr"},  64'(imem_addr), 64'd0);
        chk({tag, " wdata"}, 64'(imem_wdata), 64'd0);
        chk({tag, " miso"},  64'(miso), 64'd0);
        chk({tag, " hold"},  64'(cpu_rst_hold), 64'd1);
        chk({tag, " done"},  64'(load_done), 64'd0);
        chk({tag, " bad"},   64'(bad_op), 64'd0);
    endtask

    task automatic send_bit(input logic b, input bit drop_cs, output logic m);
        mosi = b;
        #T_HALF;
        m    = miso;
        sclk = 1'b1;
        if (drop_cs) cs_n = 1'b1;
        #T_HALF;
        sclk = 1'b0;
    endtask

    // Sends nbits of tx_q (zeros past its end), then compares against the word-level model.
    task automatic run_session(input string tag, input int nbits, input bit cs_with_last);
        logic [31:0] rx_q[$];
        logic [31:0] ms, w, e_word;
        logic [ADDR_W+31:0] e;
        logic m;
        int full, n, nw;
        bit hdr_ok, exp_done, exp_bad;
        wr_q.delete();
        ms = '0;
        cs_n = 1'b0;
        #T_HALF;
        for (int b = 0; b < nbits; b++) begin
            w = (b / 32 < tx_q.size()) ? tx_q[b / 32] : 32'h0;
            send_bit(w[31 - (b % 32)], cs_with_last && (b == nbits - 1), m);
            ms = {ms[30:0], m};
            if (b % 32 == 31) rx_q.push_back(ms);
        end
        #T_HALF;
        cs_n = 1'b1;
        #300;

        full     = nbits / 32;
        hdr_ok   = (full > 0) && (tx_q[0][31:24] == 8'hA5) && (int'(tx_q[0][15:0]) <= (1 << ADDR_W));
        n        = hdr_ok ? int'(tx_q[0][15:0]) : 0;
        nw       = hdr_ok ? ((full - 1 < n) ? full - 1 : n) : 0;
        exp_done = hdr_ok && (nw == n);
        exp_bad  = 1'b0;
        for (int k = 0; k < nw; k++) if (!op_ok(tx_q[k + 1][6:0])) exp_bad = 1'b1;

        chk({tag, " nwrites"}, 64'(wr_q.size()), 64'(nw));
        for (int k = 0; k < nw && k < wr_q.size(); k++) begin
            e = wr_q[k];
            chk({tag, " addr"}, 64'(e[ADDR_W+31:32]), 64'(k));
            chk({tag, " data"}, 64'(e[31:0]), 64'(tx_q[k + 1]));
        end
        chk({tag, " done"}, 64'(load_done), 64'(exp_done));
        chk({tag, " hold"}, 64'(cpu_rst_hold), 64'(!exp_done));
        chk({tag, " bad"},  64'(bad_op), 64'(exp_bad));
        for (int k = 0; k < rx_q.size(); k++) begin
            if (k == 0 || (hdr_ok && k <= n)) begin
                e_word = (k == 0) ? 32'h0 : tx_q[k - 1];
                chk({tag, " echo"}, 64'(rx_q[k]), 64'(e_word));
            end
        end
    endtask

    initial begin
        logic [6:0] ops[7];
        logic [6:0] op;
        logic m;
        int n, mode, nb;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                7'b1100011, 7'b1101111, 7'b0110111};
        rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        #40;
        chk_reset("reset");
        rst = 1'b0;
        #100;
        chk_reset("idle");

        tx_q = '{32'hA500_0003, 32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3};
        run_session("load3", 128, 1'b0);

        tx_q = '{32'hA500_0000};
        run_session("n0", 32, 1'b0);

        tx_q = '{32'h5A00_0002, 32'h0050_0093, 32'h00A0_0113};
        run_session("badmagic", 96, 1'b0);

        tx_q = '{32'hA500_0002, 32'h0000_0013, 32'h0010_0093};
        run_session("recover", 96, 1'b0);

        tx_q = '{32'hA500_0002, 32'h1234_5033, 32'h0000_00EF};
        run_session("trunc17", 81, 1'b0);

        tx_q = '{32'hA500_0001, 32'hFFFF_FFFF};
        run_session("badop", 64, 1'b0);

        tx_q = '{32'hA500_0101, 32'h0000_0037};
        run_session("n257", 64, 1'b0);

        tx_q = '{32'hA500_0100, 32'h0000_0037};
        run_session("n256", 64, 1'b0);

        tx_q = '{32'hA500_0002, 32'h0000_0063, 32'h0000_0023};
        run_session("cs_last", 96, 1'b1);

        // Async reset in the middle of the second data word.
        tx_q = '{32'hA500_0003, 32'h0000_0003, 32'h0000_0013, 32'h0000_0033};
        wr_q.delete();
        cs_n = 1'b0;
        #T_HALF;
        for (int b = 0; b < 74; b++) send_bit(tx_q[b / 32][31 - (b % 32)], 1'b0, m);
        #20;
        chk("midrst writes", 64'(wr_q.size()), 64'd1);
        rst = 1'b1;
        #10;
        chk_reset("midrst");
        cs_n = 1'b1;
        #100;
        rst = 1'b0;
        #200;
        chk_reset("postrst");

        for (int s = 0; s < 8; s++) begin
            n = $urandom_range(1, 4);
            tx_q.delete();
            tx_q.push_back({8'hA5, 8'($urandom), 16'(n)});
            for (int k = 0; k < n; k++) begin
                op = ($urandom_range(0, 3) == 0) ? 7'($urandom) : ops[$urandom_range(0, 6)];
                tx_q.push_back({25'($urandom), op});
            end
            mode = $urandom_range(0, 3);
            case (mode)
                1:       nb = 32 * (n + 1) + 20;
                2:       nb = $urandom_range(32, 32 * (n + 1) - 1);
                default: nb = 32 * (n + 1);
            endcase
            run_session("rand", nb, mode == 3);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
